// File: rtl/smoothing_pkg.sv
// Shared constants and width helpers for the smoothing filter slice.
package smoothing_pkg;

    localparam logic MODE_BOXCAR = 1'b0;
    localparam logic MODE_EMA    = 1'b1;

    function automatic int sum_w(input int data_w, input int log2_depth);
        return data_w + log2_depth;
    endfunction

    function automatic int acc_w(input int data_w, input int ema_shift);
        return data_w + ema_shift;
    endfunction

endpackage

// File: rtl/smoothing_window_buf.sv
// Circular delay line of 2^LOG2_DEPTH samples; rdata is the oldest entry.
module smoothing_window_buf
    import smoothing_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int LOG2_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  we,
    input  logic [DATA_W-1:0]     wdata,
    output logic [DATA_W-1:0]     rdata,
    output logic [LOG2_DEPTH-1:0] wptr
);

    localparam int D = 1 << LOG2_DEPTH;

    logic [DATA_W-1:0] mem [D];

    // A write in the clearing cycle lands as the first entry of a fresh window.
    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < D; i++) begin
                mem[i] <= '0;
            end
            wptr <= '0;
            if (we) begin
                mem[0] <= wdata;
                wptr   <= LOG2_DEPTH'(1);
            end
        end else if (we) begin
            mem[wptr] <= wdata;
            wptr      <= wptr + 1'b1;
        end
    end

    assign rdata = mem[wptr];

endmodule

// File: rtl/smoothing_filter_param.sv
// Boxcar / EMA sample smoother with valid handshake, warm-up and rounding.
module smoothing_filter_param
    import smoothing_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int LOG2_DEPTH = 2,
    parameter int EMA_SHIFT  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enb,
    input  logic              mode,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              primed
);

    localparam int SUM_W = sum_w(DATA_W, LOG2_DEPTH);
    localparam int ACC_W = acc_w(DATA_W, EMA_SHIFT);
    localparam int RND_W = ACC_W + 1;
    localparam int D     = 1 << LOG2_DEPTH;

    logic [SUM_W-1:0]      sum_q;
    logic [ACC_W-1:0]      acc_q;
    logic                  full_q;
    logic                  seeded_q;
    logic                  mode_q;

    logic [DATA_W-1:0]     buf_old;
    logic [LOG2_DEPTH-1:0] wptr;
    logic                  buf_clr;
    logic                  buf_we;

    logic                  accept;
    logic                  restart;
    logic [SUM_W-1:0]      sum_base;
    logic [DATA_W-1:0]     old_base;
    logic [LOG2_DEPTH-1:0] wptr_base;
    logic                  full_base;
    logic [ACC_W-1:0]      acc_base;
    logic                  seeded_base;

    logic [SUM_W-1:0]      sum_nxt;
    logic [SUM_W-1:0]      box_rnd;
    logic [DATA_W-1:0]     box_avg;
    logic                  box_full;
    logic [ACC_W-1:0]      acc_nxt;
    logic [RND_W-1:0]      ema_rnd;
    logic [DATA_W:0]       ema_q;
    logic [DATA_W-1:0]     ema_avg;

    assign accept  = enb & in_valid;
    assign restart = mode != mode_q;

    // A mode change wipes history, so this cycle's sample sees empty state.
    assign sum_base    = restart ? '0 : sum_q;
    assign old_base    = restart ? '0 : buf_old;
    assign wptr_base   = restart ? '0 : wptr;
    assign full_base   = restart ? 1'b0 : full_q;
    assign acc_base    = restart ? '0 : acc_q;
    assign seeded_base = restart ? 1'b0 : seeded_q;

    assign sum_nxt  = sum_base + SUM_W'(in_data) - SUM_W'(old_base);
    assign box_rnd  = sum_nxt + SUM_W'(D / 2);
    assign box_avg  = box_rnd[SUM_W-1:LOG2_DEPTH];
    assign box_full = full_base | (&wptr_base);

    assign acc_nxt = seeded_base
                   ? acc_base - (acc_base >> EMA_SHIFT) + ACC_W'(in_data)
                   : {in_data, {EMA_SHIFT{1'b0}}};
    assign ema_rnd = {1'b0, acc_nxt} + RND_W'(1 << (EMA_SHIFT - 1));
    assign ema_q   = ema_rnd[ACC_W:EMA_SHIFT];
    assign ema_avg = ema_q[DATA_W] ? '1 : ema_q[DATA_W-1:0];

    assign buf_clr = ~reset | restart;
    assign buf_we  = reset & accept & (mode == MODE_BOXCAR);

    smoothing_window_buf #(
        .DATA_W    (DATA_W),
        .LOG2_DEPTH(LOG2_DEPTH)
    ) u_buf (
        .clk  (clk),
        .clr  (buf_clr),
        .we   (buf_we),
        .wdata(in_data),
        .rdata(buf_old),
        .wptr (wptr)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            sum_q     <= '0;
            acc_q     <= '0;
            full_q    <= 1'b0;
            seeded_q  <= 1'b0;
            mode_q    <= mode;
            out_valid <= 1'b0;
            out_data  <= '0;
            primed    <= 1'b0;
        end else begin
            mode_q    <= mode;
            out_valid <= 1'b0;
            if (restart) begin
                sum_q    <= '0;
                acc_q    <= '0;
                full_q   <= 1'b0;
                seeded_q <= 1'b0;
                primed   <= 1'b0;
            end
            if (accept) begin
                if (mode == MODE_BOXCAR) begin
                    sum_q  <= sum_nxt;
                    full_q <= box_full;
                    if (box_full) begin
                        primed    <= 1'b1;
                        out_valid <= 1'b1;
                        out_data  <= box_avg;
                    end
                end else begin
                    acc_q     <= acc_nxt;
                    seeded_q  <= 1'b1;
                    primed    <= 1'b1;
                    out_valid <= 1'b1;
                    out_data  <= ema_avg;
                end
            end
        end
    end

endmodule

// File: tb/tb_smoothing_filter_param.sv
// Bench for smoothing_filter_param: queue/arithmetic reference model plus directed literals.
module tb_smoothing_filter_param;

    localparam int DW = 8;
    localparam int L  = 2;
    localparam int K  = 2;
    localparam int D  = 1 << L;
    localparam int KS = 1 << K;

    logic          clk = 1'b0;
    logic          reset;
    logic          enb;
    logic          mode;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          primed;

    int checks = 0;
    int errors = 0;
    bit run    = 1'b0;

    int win[$];
    int ema_acc;
    bit ema_seeded;
    int m_mode;
    int e_valid;
    int e_data;
    int e_primed;

    smoothing_filter_param #(
        .DATA_W    (DW),
        .LOG2_DEPTH(L),
        .EMA_SHIFT (K)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .enb      (enb),
        .mode     (mode),
        .in_valid (in_valid),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_data (out_data),
        .primed   (primed)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d, expected %0d",
                     name, $time, act, exp);
        end
    endtask

    // Expected outputs after the coming rising edge, from the current inputs.
    function automatic void model_step();
        int s;
        if (!reset) begin
            win.delete();
            ema_acc    = 0;
            ema_seeded = 0;
            m_mode     = int'(mode);
            e_valid    = 0;
            e_data     = 0;
            e_primed   = 0;
            return;
        end
        e_valid = 0;
        if (int'(mode) != m_mode) begin
            win.delete();
            ema_acc    = 0;
            ema_seeded = 0;
            e_primed   = 0;
        end
        m_mode = int'(mode);
        if (enb && in_valid) begin
            if (mode == 1'b0) begin
                win.push_back(int'(in_data));
                if (win.size() > D) void'(win.pop_front());
                if (win.size() == D) begin
                    s = 0;
                    foreach (win[i]) s += win[i];
                    e_data   = (s + D / 2) / D;
                    e_valid  = 1;
                    e_primed = 1;
                end
            end else begin
                if (!ema_seeded) ema_acc = int'(in_data) * KS;
                else ema_acc = ema_acc - ema_acc / KS + int'(in_data);
                ema_seeded = 1;
                e_primed   = 1;
                e_valid    = 1;
                e_data     = (ema_acc + KS / 2) / KS;
                if (e_data > 255) e_data = 255;
            end
        end
    endfunction

    always @(negedge clk) begin
        if (run) begin
            chk("out_valid", 32'(out_valid), e_valid);
            chk("primed", 32'(primed), e_primed);
            chk("out_data", 32'(out_data), e_data);
        end
    end

    task automatic step(input bit r, input bit e, input bit m,
                        input bit v, input int d);
        reset    = r;
        enb      = e;
        mode     = m;
        in_valid = v;
        in_data  = DW'(d);
        model_step();
        @(negedge clk);
        #1;
    endtask

    task automatic lit(input string name, input int v, input int d, input int p);
        chk({name, "_valid"}, 32'(out_valid), v);
        chk({name, "_data"}, 32'(out_data), d);
        chk({name, "_primed"}, 32'(primed), p);
    endtask

    initial begin
        int d;
        bit m;
        reset = 0; enb = 0; mode = 0; in_valid = 0; in_data = '0;
        @(negedge clk);
        #1;
        step(0, 1, 0, 1, 7);
        run = 1'b1;
        step(0, 1, 0, 1, 7);
        lit("reset", 0, 0, 0);

        step(1, 1, 0, 1, 10);
        lit("fill1", 0, 0, 0);
        step(1, 1, 0, 1, 20);
        step(1, 1, 0, 1, 30);
        lit("fill3", 0, 0, 0);
        step(1, 1, 0, 1, 40);
        lit("fill4", 1, 25, 1);
        step(1, 1, 0, 1, 50);
        lit("slide", 1, 35, 1);

        for (int i = 0; i < 8; i++) step(1, 1, 0, 1, 255);
        lit("fullscale", 1, 255, 1);

        step(0, 1, 0, 0, 0);
        step(1, 1, 0, 1, 10);
        step(1, 1, 0, 1, 20);
        for (int i = 0; i < 5; i++) step(1, 0, 0, 1, 99);
        lit("stall", 0, 0, 0);
        step(1, 1, 0, 1, 30);
        step(1, 1, 0, 1, 40);
        lit("resume", 1, 25, 1);

        step(1, 1, 1, 1, 100);
        lit("ema_seed", 1, 100, 1);
        step(1, 1, 1, 1, 0);
        lit("ema_1", 1, 75, 1);
        step(1, 1, 1, 1, 0);
        lit("ema_2", 1, 56, 1);

        step(1, 1, 0, 1, 1);
        step(1, 1, 0, 1, 2);
        step(1, 1, 0, 1, 3);
        step(0, 1, 0, 1, 4);
        lit("midreset", 0, 0, 0);
        step(1, 1, 0, 1, 8);
        step(1, 1, 0, 1, 8);
        step(1, 1, 0, 1, 8);
        lit("refill3", 0, 0, 0);
        step(1, 1, 0, 1, 9);
        lit("refill4", 1, 8, 1);

        step(1, 1, 1, 1, 80);
        lit("sw_ema", 1, 80, 1);
        step(1, 1, 0, 1, 5);
        lit("sw_box1", 0, 80, 0);
        step(1, 1, 0, 1, 5);
        step(1, 1, 0, 1, 5);
        lit("sw_box3", 0, 80, 0);
        step(1, 1, 0, 1, 6);
        lit("sw_box4", 1, 5, 1);

        m = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            case ($urandom_range(0, 3))
                0: d = 0;
                1: d = 255;
                default: d = int'($urandom_range(0, 255));
            endcase
            if ($urandom_range(0, 39) == 0) m = ~m;
            step($urandom_range(0, 63) != 0, $urandom_range(0, 9) != 0, m,
                 $urandom_range(0, 9) < 7, d);
        end

        run = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
